// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: fetch FSM state encoding and IncPCRA bit positions.
// Every pipeline stage imports these so that encodings stay consistent.
package pipeline_pkg;

   typedef enum logic [1:0] {
      ST_HOLD = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } fetch_state_t;

   localparam int INC_PC_BIT = 0;
   localparam int INC_RA_BIT = 1;

   localparam int ADDR_W = 16;

endpackage

// File: rtl/pc_ra_register.sv
// One address register with asynchronous reset, a load port and a +1 increment.
// If load and inc are both asserted, the load wins.
module pc_ra_register #(
   parameter int               WIDTH       = 16,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             inc,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] value
);

   // The increment wraps modulo 2^WIDTH and raises no carry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value <= RESET_VALUE;
      end else if (load) begin
         value <= load_value;
      end else if (inc) begin
         value <= value + WIDTH'(1);
      end
   end

endmodule

// File: rtl/pc_ra_fetch_unit.sv
// Fetch unit holding two swappable address registers (PC and return address)
// with a HOLD/RUN/HALT sequencer that gates instruction fetch.
module pc_ra_fetch_unit
   import pipeline_pkg::*;
#(
   parameter logic [15:0] RESET_VECTOR = 16'h0000,
   parameter int          HOLD_CYCLES  = 4
) (
   input  logic         ClockIn,
   input  logic         ResetIn,
   input  logic [1:0]   IncPCRA,
   input  logic         FlipReq,
   input  logic         Break,
   input  logic         Continue,
   input  logic         BusRequest,
   input  logic         FetchSurpress,
   input  logic         LoadPC,
   input  logic         LoadRA,
   input  logic [15:0]  XferBus,
   output logic [15:0]  FetchAddr,
   output logic [15:0]  RAOut,
   output logic         PCRA_Flip,
   output logic         FetchEnable,
   output logic         Halted,
   output fetch_state_t dbg_state
);

   localparam int HOLD_W = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST =
      (HOLD_CYCLES > 0) ? HOLD_W'(HOLD_CYCLES - 1) : '0;

   fetch_state_t      state;
   fetch_state_t      state_next;
   logic [HOLD_W-1:0] hold_cnt;
   logic              hold_done;
   logic              run;
   logic              flip;
   logic              inc_pc;
   logic              inc_ra;
   logic              r0_load;
   logic              r0_inc;
   logic              r1_load;
   logic              r1_inc;
   logic [15:0]       r0_value;
   logic [15:0]       r1_value;

   assign hold_done = (hold_cnt == HOLD_LAST);

   // State register and post-reset hold counter.
   always_ff @(posedge ClockIn or negedge ResetIn) begin
      if (!ResetIn) begin
         state    <= ST_HOLD;
         hold_cnt <= '0;
      end else begin
         state <= state_next;
         if (state == ST_HOLD && !hold_done) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
         end
      end
   end

   // Break is honoured over Continue when both arrive while halted.
   always_comb begin
      state_next = state;
      case (state)
         ST_HOLD: if (hold_done) state_next = ST_RUN;
         ST_RUN:  if (Break) state_next = ST_HALT;
         ST_HALT: if (Continue && !Break) state_next = ST_RUN;
         default: state_next = ST_HOLD;
      endcase
   end

   // FetchEnable is the valid qualifier for MEMDATA towards stage 0: stage 0 has no
   // ready back-pressure, it consumes the byte in every cycle FetchEnable is high.
   always_comb begin
      run         = (state == ST_RUN);
      FetchEnable = run & ~BusRequest & ~FetchSurpress;
      Halted      = (state == ST_HALT);
      dbg_state   = state;
   end

   assign inc_pc = IncPCRA[INC_PC_BIT] & FetchEnable;
   assign inc_ra = IncPCRA[INC_RA_BIT] & run & ~BusRequest;

   // Requests are routed by the roles held this cycle; a flip only affects later cycles.
   assign r0_load = flip ? LoadRA : LoadPC;
   assign r0_inc  = flip ? inc_ra : inc_pc;
   assign r1_load = flip ? LoadPC : LoadRA;
   assign r1_inc  = flip ? inc_pc : inc_ra;

   always_ff @(posedge ClockIn or negedge ResetIn) begin
      if (!ResetIn) begin
         flip <= 1'b0;
      end else if (run && FlipReq) begin
         flip <= ~flip;
      end
   end

   pc_ra_register #(
      .WIDTH       (16),
      .RESET_VALUE (RESET_VECTOR)
   ) u_r0 (
      .clk        (ClockIn),
      .rst_n      (ResetIn),
      .load       (r0_load),
      .inc        (r0_inc),
      .load_value (XferBus),
      .value      (r0_value)
   );

   pc_ra_register #(
      .WIDTH       (16),
      .RESET_VALUE (16'h0000)
   ) u_r1 (
      .clk        (ClockIn),
      .rst_n      (ResetIn),
      .load       (r1_load),
      .inc        (r1_inc),
      .load_value (XferBus),
      .value      (r1_value)
   );

   assign PCRA_Flip = flip;
   assign FetchAddr = flip ? r1_value : r0_value;
   assign RAOut     = flip ? r0_value : r1_value;

endmodule

// File: tb/tb_pc_ra_fetch_unit.sv
// Bench for pc_ra_fetch_unit: directed scenarios plus randomized traffic,
// all checked against a role-level reference model of the fetch unit.
module tb_pc_ra_fetch_unit;

   localparam logic [15:0] RV    = 16'h0000;
   localparam int          HOLDN = 4;
   localparam int          M_HOLD = 0;
   localparam int          M_RUN  = 1;
   localparam int          M_HALT = 2;

   // clock/reset and DUT signals
   logic        ClockIn = 1'b0;
   logic        ResetIn;
   logic [1:0]  IncPCRA;
   logic        FlipReq, Break, Continue, BusRequest, FetchSurpress, LoadPC, LoadRA;
   logic [15:0] XferBus;
   logic [15:0] FetchAddr, RAOut;
   logic        PCRA_Flip, FetchEnable, Halted;
   logic [1:0]  dbg_state;

   always #5 ClockIn = ~ClockIn;

   pc_ra_fetch_unit #(
      .RESET_VECTOR (RV),
      .HOLD_CYCLES  (HOLDN)
   ) dut (
      .ClockIn       (ClockIn),
      .ResetIn       (ResetIn),
      .IncPCRA       (IncPCRA),
      .FlipReq       (FlipReq),
      .Break         (Break),
      .Continue      (Continue),
      .BusRequest    (BusRequest),
      .FetchSurpress (FetchSurpress),
      .LoadPC        (LoadPC),
      .LoadRA        (LoadRA),
      .XferBus       (XferBus),
      .FetchAddr     (FetchAddr),
      .RAOut         (RAOut),
      .PCRA_Flip     (PCRA_Flip),
      .FetchEnable   (FetchEnable),
      .Halted        (Halted),
      .dbg_state     (dbg_state)
   );

   // scoreboard
   int          tests = 0;
   int          fails = 0;
   logic [15:0] exp_q[$];

   // reference model: the PC/RA values held by role, plus run mode
   logic [15:0] m_pc, m_ra;
   bit          m_flip;
   int          m_mode;
   int          m_hold_left;

   logic [15:0] obs_addr, obs_ra;
   logic        obs_flip, obs_fe, obs_halt;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc        = RV;
      m_ra        = 16'h0000;
      m_flip      = 1'b0;
      m_mode      = M_HOLD;
      m_hold_left = HOLDN;
   endtask

   task automatic model_step();
      logic [15:0] nxt_pc, nxt_ra;
      bit running, fe;
      running = (m_mode == M_RUN);
      fe      = running && !BusRequest && !FetchSurpress;
      nxt_pc  = m_pc;
      nxt_ra  = m_ra;
      if (LoadPC) nxt_pc = XferBus;
      else if (IncPCRA[0] && fe) nxt_pc = m_pc + 16'd1;
      if (LoadRA) nxt_ra = XferBus;
      else if (IncPCRA[1] && running && !BusRequest) nxt_ra = m_ra + 16'd1;
      // a role swap exchanges which value is the PC after the updates land
      if (running && FlipReq) begin
         m_pc   = nxt_ra;
         m_ra   = nxt_pc;
         m_flip = !m_flip;
      end else begin
         m_pc = nxt_pc;
         m_ra = nxt_ra;
      end
      case (m_mode)
         M_HOLD: begin
            m_hold_left--;
            if (m_hold_left <= 0) m_mode = M_RUN;
         end
         M_RUN:  if (Break) m_mode = M_HALT;
         default: if (Continue && !Break) m_mode = M_RUN;
      endcase
   endtask

   // driver: one clock cycle of stimulus, compared against the model mid-cycle
   task automatic drive_cycle(input logic [1:0] inc, input logic flp, input logic brk,
                              input logic cont, input logic bus, input logic sup,
                              input logic lpc, input logic lra, input logic [15:0] x);
      @(negedge ClockIn);
      IncPCRA = inc; FlipReq = flp; Break = brk; Continue = cont;
      BusRequest = bus; FetchSurpress = sup; LoadPC = lpc; LoadRA = lra; XferBus = x;
      #1;
      obs_addr = FetchAddr; obs_ra = RAOut; obs_flip = PCRA_Flip;
      obs_fe = FetchEnable; obs_halt = Halted;
      check_eq("fetch_addr", obs_addr, m_pc);
      check_eq("ra_out", obs_ra, m_ra);
      check_eq("pcra_flip", obs_flip, m_flip);
      check_eq("fetch_enable", obs_fe, (m_mode == M_RUN) && !bus && !sup);
      check_eq("halted", obs_halt, m_mode == M_HALT);
      model_step();
   endtask

   task automatic idle();
      drive_cycle(2'b00, 0, 0, 0, 0, 0, 0, 0, 16'h0000);
   endtask

   // asynchronous reset asserted between clock edges
   task automatic reset_pulse();
      @(posedge ClockIn);
      #2;
      ResetIn = 1'b0;
      #1;
      check_eq("rst_fetch_addr", FetchAddr, RV);
      check_eq("rst_ra_out", RAOut, 16'h0000);
      check_eq("rst_flip", PCRA_Flip, 1'b0);
      check_eq("rst_halted", Halted, 1'b0);
      check_eq("rst_fetch_enable", FetchEnable, 1'b0);
      model_reset();
      #1;
      ResetIn = 1'b1;
   endtask

   task automatic hold_window();
      for (int i = 0; i < HOLDN; i++) begin
         idle();
         check_eq("hold_fe_low", obs_fe, 1'b0);
      end
      idle();
      check_eq("hold_fe_high", obs_fe, 1'b1);
   endtask

   initial begin
      IncPCRA = '0; FlipReq = 0; Break = 0; Continue = 0; BusRequest = 0;
      FetchSurpress = 0; LoadPC = 0; LoadRA = 0; XferBus = '0;
      ResetIn = 1'b0;
      model_reset();
      #3;
      check_eq("init_fetch_addr", FetchAddr, RV);
      check_eq("init_fetch_enable", FetchEnable, 1'b0);
      check_eq("init_halted", Halted, 1'b0);
      #5;
      ResetIn = 1'b1;

      // reset then idle
      hold_window();
      check_eq("idle_fetch_addr", obs_addr, 16'h0000);

      // PC wraps through FFFF
      drive_cycle(2'b00, 0, 0, 0, 0, 0, 1, 0, 16'hFFFE);
      exp_q.push_back(16'hFFFE);
      exp_q.push_back(16'hFFFF);
      exp_q.push_back(16'h0000);
      exp_q.push_back(16'h0001);
      for (int i = 0; i < 3; i++) begin
         drive_cycle(2'b01, 0, 0, 0, 0, 0, 0, 0, 16'h0000);
         check_eq("wrap_seq", obs_addr, exp_q.pop_front());
      end
      idle();
      check_eq("wrap_seq", obs_addr, exp_q.pop_front());

      // flip in the same cycle as both increments
      drive_cycle(2'b00, 0, 0, 0, 0, 0, 1, 0, 16'h0100);
      drive_cycle(2'b00, 0, 0, 0, 0, 0, 0, 1, 16'h0200);
      drive_cycle(2'b11, 1, 0, 0, 0, 0, 0, 0, 16'h0000);
      idle();
      check_eq("flip_addr", obs_addr, 16'h0201);
      check_eq("flip_ra", obs_ra, 16'h0101);
      check_eq("flip_flag", obs_flip, 1'b1);

      // bus request blocks fetch and PC increment, RA load still lands
      drive_cycle(2'b11, 0, 0, 0, 1, 0, 0, 1, 16'h1234);
      check_eq("bus_fe", obs_fe, 1'b0);
      idle();
      check_eq("bus_addr", obs_addr, 16'h0201);
      check_eq("bus_ra", obs_ra, 16'h1234);

      // break freezes the PC; break with continue stays halted
      drive_cycle(2'b01, 0, 1, 0, 0, 0, 0, 0, 16'h0000);
      for (int i = 0; i < 10; i++) begin
         drive_cycle(2'b01, 0, 0, 0, 0, 0, 0, 0, 16'h0000);
         check_eq("halt_flag", obs_halt, 1'b1);
         check_eq("halt_frozen", obs_addr, 16'h0202);
      end
      drive_cycle(2'b01, 0, 1, 1, 0, 0, 0, 0, 16'h0000);
      drive_cycle(2'b01, 0, 0, 1, 0, 0, 0, 0, 16'h0000);
      check_eq("brk_cont_halt", obs_halt, 1'b1);
      drive_cycle(2'b01, 0, 0, 0, 0, 0, 0, 0, 16'h0000);
      check_eq("resume_halt", obs_halt, 1'b0);
      idle();
      check_eq("resume_addr", obs_addr, 16'h0203);

      // reset while halted with roles flipped
      drive_cycle(2'b00, 0, 1, 0, 0, 0, 0, 0, 16'h0000);
      idle();
      check_eq("pre_rst_halt", obs_halt, 1'b1);
      check_eq("pre_rst_flip", obs_flip, 1'b1);
      reset_pulse();
      hold_window();

      // randomized traffic
      for (int n = 0; n < 600; n++) begin
         logic [15:0] x;
         x = ($urandom_range(0, 3) == 0) ? (16'hFFFF - 16'($urandom_range(0, 2))) : 16'($urandom);
         drive_cycle(2'($urandom_range(0, 3)), $urandom_range(0, 3) == 0,
                     $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0,
                     $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                     $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, x);
         if ($urandom_range(0, 149) == 0) reset_pulse();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
